// File: rtl/div_unit_radix.sv
// Iterative restoring divider retiring BPC quotient bits per cycle (RISC-V DIV/DIVU/REM/REMU semantics).
// Optional early termination on dividend leading zeros is compiled in by defining DIV_UNIT_EARLY_TERM_EN.
module div_unit_radix #(
    parameter int XLEN = 32,
    parameter int BPC  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_unsigned,
    input  logic            is_rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int N  = XLEN / BPC;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            fire, accept;
    logic            dvd_neg, dsr_neg, div_zero, ovf;
    logic [XLEN-1:0] dvd_mag, dsr_mag;
    logic [XLEN-1:0] load_quo;
    logic [CW-1:0]   load_cnt;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE) & ~rst;
    assign busy      = (state_q != IDLE) & ~rst;
    assign result    = rst ? '0 : result_q;

    assign fire   = in_valid & in_ready & ~kill;
    assign accept = out_valid & out_ready;

    assign dvd_neg  = ~is_unsigned & dividend[XLEN-1];
    assign dsr_neg  = ~is_unsigned & divisor[XLEN-1];
    assign dvd_mag  = dvd_neg ? -dividend : dividend;
    assign dsr_mag  = dsr_neg ? -divisor : divisor;
    assign div_zero = (divisor == '0);
    assign ovf      = ~is_unsigned & (dividend == MIN_INT) & (divisor == '1);

    // quo_q holds the not-yet-consumed dividend bits above the quotient bits retired so far
    logic [XLEN-1:0] rem_s [BPC+1];
    logic [XLEN-1:0] quo_s [BPC+1];

    assign rem_s[0] = rem_q;
    assign quo_s[0] = quo_q;

    for (genvar gi = 0; gi < BPC; gi++) begin : g_step
        logic [XLEN:0] shifted;
        logic [XLEN:0] trial;
        assign shifted        = {rem_s[gi], quo_s[gi][XLEN-1]};
        assign trial          = shifted - {1'b0, dsr_q};
        assign rem_s[gi+1]    = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        assign quo_s[gi+1]    = {quo_s[gi][XLEN-2:0], ~trial[XLEN]};
    end

    assign quo_fix = neg_quo_q ? -quo_s[BPC] : quo_s[BPC];
    assign rem_fix = neg_rem_q ? -rem_s[BPC] : rem_s[BPC];

`ifdef DIV_UNIT_EARLY_TERM_EN
    // Skip whole BPC-bit groups of leading zeros; a zero dividend still takes one cycle
    always_comb begin
        int lz;
        int blocks;
        lz = XLEN;
        for (int i = 0; i < XLEN; i++) begin
            if (dvd_mag[i]) lz = XLEN - 1 - i;
        end
        blocks   = lz / BPC;
        load_quo = dvd_mag << (blocks * BPC);
        load_cnt = (blocks >= N) ? CW'(1) : CW'(N - blocks);
    end
`else
    assign load_quo = dvd_mag;
    assign load_cnt = CW'(N);
`endif

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (div_zero) begin
                        result_d = is_rem ? dividend : '1;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = is_rem ? '0 : MIN_INT;
                        state_d  = DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = load_quo;
                        dsr_d     = dsr_mag;
                        cnt_d     = load_cnt;
                        is_rem_d  = is_rem;
                        neg_quo_d = dvd_neg ^ dsr_neg;
                        neg_rem_d = dvd_neg;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_s[BPC];
                quo_d = quo_s[BPC];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_d = is_rem_q ? rem_fix : quo_fix;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsr_q     <= dsr_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_div_unit_radix.sv
// Bench for div_unit_radix: 32-bit/radix-4 instance driven from a vector table and scoreboard,
// plus an 8-bit/radix-2 instance for the single-bit-per-cycle latency case.
module tb_div_unit_radix;

    logic        clk = 1'b0;
    logic        rst, kill, in_valid, in_ready, is_unsigned, is_rem;
    logic        out_valid, out_ready, busy;
    logic [31:0] dividend, divisor, result;

    logic       s_kill, s_in_valid, s_in_ready, s_is_unsigned, s_is_rem;
    logic       s_out_valid, s_out_ready, s_busy;
    logic [7:0] s_dividend, s_divisor, s_result;

    int n_vec  = 0;
    int n_miss = 0;
    int n_txn  = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    div_unit_radix #(.XLEN(32), .BPC(2)) dut (
        .clk(clk), .rst(rst), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
        .is_unsigned(is_unsigned), .is_rem(is_rem), .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    div_unit_radix #(.XLEN(8), .BPC(1)) dut_s (
        .clk(clk), .rst(rst), .kill(s_kill), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .is_unsigned(s_is_unsigned), .is_rem(s_is_rem), .dividend(s_dividend), .divisor(s_divisor),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result), .busy(s_busy)
    );

    typedef struct {
        bit          uns;
        bit          rm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(bit uns, bit rm, logic [31:0] a, logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
        if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'd0 : 32'h8000_0000;
        if (uns) return rm ? (a % b) : (a / b);
        sa = a;
        sb = b;
        return rm ? (sa % sb) : (sa / sb);
    endfunction

    function automatic int ref_lat(bit uns, logic [31:0] a, logic [31:0] b);
        if (b == 32'd0 || (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`ifdef DIV_UNIT_EARLY_TERM_EN
        begin
            logic [31:0] mag;
            int lz, c;
            mag = (!uns && a[31]) ? -a : a;
            lz = 32;
            for (int i = 0; i < 32; i++) if (mag[i]) lz = 31 - i;
            c = 16 - lz / 2;
            if (c < 1) c = 1;
            return c + 1;
        end
`else
        return 17;
`endif
    endfunction

    // Called at posedge+1 with the unit idle; stall extends the out_ready=0 window after out_valid rises.
    task automatic run_op(input bit uns, input bit rm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int stall);
        int lat;
        logic [31:0] held, exp_r;
        out_ready   = (stall == 0);
        in_valid    = 1'b1;
        is_unsigned = uns;
        is_rem      = rm;
        dividend    = a;
        divisor     = b;
        check("in_ready_before_fire", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        dividend    = $urandom;
        divisor     = $urandom;
        is_rem      = ~rm;
        is_unsigned = ~uns;
        sb_q.push_back(exp);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(ref_lat(uns, a, b)));
        held = result;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, held});
        end
        out_ready = 1'b1;
        check("in_ready_accept_cycle", 64'(in_ready), 64'd0);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            exp_r = sb_q.pop_front();
            check("result", 64'(result), 64'(exp_r));
        end
        n_txn++;
        $display("txn %0d: %s%s 0x%08h / 0x%08h -> 0x%08h (exp 0x%08h) in %0d cycles",
                 n_txn, rm ? "REM" : "DIV", uns ? "U" : "", a, b, result, exp, lat);
        @(posedge clk); #1;
        check("idle_after_accept", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int   seen, lat;
        logic [31:0] a, b;
        bit uns, rm;

        vecs[0]  = '{1'b1, 1'b0, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{1'b1, 1'b1, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{1'b0, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{1'b0, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[5]  = '{1'b0, 1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[6]  = '{1'b0, 1'b1, 32'd5,          32'd0,          32'd5};
        vecs[7]  = '{1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[8]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[9]  = '{1'b1, 1'b0, 32'd5,          32'd2,          32'd2};
        vecs[10] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[11] = '{1'b0, 1'b0, 32'h8000_0000,  32'd1,          32'h8000_0000};

        rst = 1'b1; kill = 1'b0; in_valid = 1'b0; is_unsigned = 1'b0; is_rem = 1'b0;
        dividend = '0; divisor = '0; out_ready = 1'b1;
        s_kill = 1'b0; s_in_valid = 1'b0; s_is_unsigned = 1'b0; s_is_rem = 1'b0;
        s_dividend = '0; s_divisor = '0; s_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {in_ready, out_valid, busy, result}, 35'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // fire in the same cycle as kill must be dropped
        @(posedge clk); #1;
        in_valid = 1'b1; kill = 1'b1; is_unsigned = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        check("kill_blocks_fire", {busy, in_ready}, 2'b01);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].uns, vecs[i].rm, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

        run_op(1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 10);

        // kill five cycles into CALC
        in_valid = 1'b1; is_unsigned = 1'b1; is_rem = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_in_calc", 64'(busy), 64'd1);
        repeat (4) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("idle_after_kill", {busy, in_ready, out_valid}, 3'b010);
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1; end
        check("no_out_valid_after_kill", 64'(seen), 64'd0);
        run_op(1'b1, 1'b0, 32'd9, 32'd3, 32'd3, 0);

        // reset five cycles into CALC
        in_valid = 1'b1; is_unsigned = 1'b1; is_rem = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("outputs_during_rst", {in_ready, out_valid, busy}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("in_ready_after_mid_rst", {in_ready, busy}, 2'b10);
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1; end
        check("no_out_valid_after_rst", 64'(seen), 64'd0);
        run_op(1'b1, 1'b0, 32'd9, 32'd3, 32'd3, 0);

        for (int i = 0; i < 20; i++) begin
            uns = 1'($urandom_range(0, 1));
            rm  = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(1, 31);
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 20);
                3:       b = -($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op(uns, rm, a, b, ref_res(uns, rm, a, b), 0);
        end

        // 8-bit, one bit per cycle: 8 CALC cycles plus the DONE cycle
        for (int k = 0; k < 2; k++) begin
            s_is_unsigned = 1'b1; s_is_rem = 1'(k); s_dividend = 8'd200; s_divisor = 8'd3;
            s_in_valid = 1'b1;
            check("s_in_ready", 64'(s_in_ready), 64'd1);
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            lat = 1;
            while (!s_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
            check("s_latency", 64'(lat), 64'd9);
            check("s_result", 64'(s_result), (k == 0) ? 64'd66 : 64'd2);
            n_txn++;
            $display("txn %0d: %s 200 / 3 (8-bit) -> %0d in %0d cycles", n_txn, k ? "REMU" : "DIVU", s_result, lat);
            @(posedge clk); #1;
        end

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
